mining_sequencer: RTL
=====================

Name: mining_sequencer

Overview:
- Nonce-sweep controller for the double-SHA256 core.
- Takes a 76-byte header prefix, a target, and a nonce range from the host/SPI register file.
- For each nonce it resets and starts the core, waits for its digest, and compares the digest against the target.
- Reports the first winning nonce, or reports exhaustion or a timeout. Sits between the host register block and the sha256 core instance.

Parameters:
- TIMEOUT_CYCLES, 512: max cycles in WAIT per hash before the error abort.
- STOP_ON_FIRST, 1: 1 = stop at the first hit; 0 = report the hit and continue the sweep after found_ack.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config word valid
- cfg_ready  out  1  high only in IDLE
- cfg_prefix  in  608  header bytes 0..75, big-endian byte order, maps to block[639:32]
- cfg_target  in  256  target as an unsigned integer
- cfg_nonce_start  in  32  first nonce
- cfg_nonce_end  in  32  last nonce, inclusive
- abort  in  1  synchronous abort request
- found_ack  in  1  host acknowledge of a hit
- busy  out  1  not IDLE
- found_valid  out  1  hit pending; held until found_ack
- found_nonce  out  32  winning nonce
- found_hash  out  256  winning digest, byte-reversed (Bitcoin LE integer form)
- exhausted  out  1  sticky; range done without a pending hit
- timeout_err  out  1  sticky; core exceeded TIMEOUT_CYCLES
- nonce_cur  out  32  nonce currently being hashed
- core_rst_n  out  1  synchronous per-hash reset to the core
- core_start  out  1  start pulse to the core
- core_block  out  640  {prefix, bswap32(nonce_cur)}
- core_hash  in  256  core digest
- core_done  in  1  core done; sticky until the core is reset

Behaviour:
- Reset values: all outputs 0, except cfg_ready=1 and core_rst_n=0. State is IDLE.
- States: IDLE, CRST, CSTART, WAIT, CHECK, HOLD, DONE.
- IDLE:
  - On cfg_valid && cfg_ready: latch prefix, target, start, and end.
  - Set nonce_cur=start. Clear exhausted and timeout_err. Go to CRST.
- CRST (1 cycle): core_rst_n=0. Otherwise core_rst_n=1 in all non-IDLE states. Go to CSTART.
- CSTART (1 cycle): core_start=1, core_block stable. Go to WAIT; clear the timeout counter.
- WAIT:
  - core_done=1 goes to CHECK.
  - If the counter reaches TIMEOUT_CYCLES, set timeout_err and go to DONE.
- CHECK (1 cycle):
  - Compute le = byte-reverse of core_hash (byte 0 of core_hash becomes the LS byte).
  - Hit if le <= target (unsigned, 256-bit).
  - On a hit: found_nonce=nonce_cur, found_hash=le, found_valid=1, go to HOLD.
  - On a miss:
    - If nonce_cur==end: exhausted=1, go to DONE.
    - Otherwise nonce_cur+1 (32-bit wrap allowed; start>end sweeps through 0xFFFFFFFF→0), go to CRST.
- HOLD: wait for found_ack, which clears found_valid.
  - STOP_ON_FIRST=1: go to DONE.
  - STOP_ON_FIRST=0: if nonce_cur==end, set exhausted and go to DONE; otherwise increment and go to CRST.
- DONE (1 cycle): go to IDLE. exhausted, timeout_err, and found_nonce/hash retain their values until the next cfg accept.
- abort:
  - In any non-IDLE state except HOLD, go to DONE next cycle and hold core_rst_n=0 for that cycle.
  - In HOLD, abort is ignored until found_ack.
  - abort in IDLE: no effect.
- found_ack outside HOLD: ignored.
- cfg_valid while busy: ignored; cfg_ready=0.
- Per-hash overhead: 3 cycles (CRST + CSTART + CHECK) plus the core latency.
- core_block is registered and changes only in CHECK/HOLD transitions, never during WAIT.
- Asynchronous reset mid-sweep: everything returns to reset values, and core_rst_n is asserted immediately.

Decomposition:
- Shared package mining_pkg:
  - State encoding localparams.
  - PREFIX_W=608, HASH_W=256, NONCE_W=32.
  - bswap32 function.
  - 256-bit byte-reverse function.
- Optional sub-module target_cmp: combinational byte-reverse plus 256-bit unsigned <= compare.
  - Its output is registered in CHECK if timing requires, which adds 1 cycle.
  - Otherwise it is inlined.

Test Plan:
- Genesis header prefix, target = 0x00000000FFFF0000…00 (bits 0x1d00ffff), range 0x7C2BAC1B..0x7C2BAC1F, real core:
  - found_valid with found_nonce=0x7C2BAC1D.
  - found_hash=0x000000000019d6689c085ae165831e934ff763ae46a2a6c172b3f1b60a8ce26f.
  - Exactly 3 core_start pulses.
- Same header, range 0x00000000..0x00000003, target=0 → no hit; exhausted=1 after 4 hashes; found_valid never set.
- Target = all-ones, STOP_ON_FIRST=0, range 0xFFFFFFFE..0x00000001 with acks:
  - 4 hits, nonces FFFFFFFE, FFFFFFFF, 0, 1 (wrap checked); then exhausted=1.
- Stub core that never asserts core_done → timeout_err=1 exactly TIMEOUT_CYCLES after core_start; busy drops 1 cycle later.
- abort asserted mid-WAIT on hash 2 → core_rst_n low the next cycle, IDLE within 2 cycles, cfg_ready=1, no found_valid.
- rst_n pulsed low mid-sweep → all outputs at reset values; a new cfg is accepted and sweeps correctly.

Source files
------------

// File: rtl/mining_pkg.sv
// Shared types, widths and byte-order helpers for the nonce-sweep sequencer.
package mining_pkg;

  localparam int unsigned PREFIX_W = 608;
  localparam int unsigned HASH_W   = 256;
  localparam int unsigned NONCE_W  = 32;
  localparam int unsigned BLOCK_W  = PREFIX_W + NONCE_W;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CRST   = 3'd1,
    ST_CSTART = 3'd2,
    ST_WAIT   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_HOLD   = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Sweep configuration captured from the host on accept.
  typedef struct packed {
    logic [PREFIX_W-1:0] prefix;
    logic [HASH_W-1:0]   target;
    logic [NONCE_W-1:0]  nonce_end;
  } cfg_t;

  // Reverse the byte order of a 32-bit word.
  function automatic logic [NONCE_W-1:0] bswap32(input logic [NONCE_W-1:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Reverse the byte order of a 256-bit digest (byte 0 at [255:248] lands at [7:0]).
  function automatic logic [HASH_W-1:0] bswap256(input logic [HASH_W-1:0] h);
    logic [HASH_W-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      r[8*i +: 8] = h[HASH_W-1-8*i -: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mining_sequencer_if.sv
// Host configuration/result bus plus the core-control bus of the sequencer.
interface mining_sequencer_if;
  import mining_pkg::*;

  logic                cfg_valid;
  logic                cfg_ready;
  logic [PREFIX_W-1:0] cfg_prefix;
  logic [HASH_W-1:0]   cfg_target;
  logic [NONCE_W-1:0]  cfg_nonce_start;
  logic [NONCE_W-1:0]  cfg_nonce_end;
  logic                abort;
  logic                found_ack;
  logic                busy;
  logic                found_valid;
  logic [NONCE_W-1:0]  found_nonce;
  logic [HASH_W-1:0]   found_hash;
  logic                exhausted;
  logic                timeout_err;
  logic [NONCE_W-1:0]  nonce_cur;
  logic                core_rst_n;
  logic                core_start;
  logic [BLOCK_W-1:0]  core_block;
  logic [HASH_W-1:0]   core_hash;
  logic                core_done;

  // Environment side: host register file plus the sha256 core.
  modport master (
    output cfg_valid, cfg_prefix, cfg_target, cfg_nonce_start, cfg_nonce_end,
    output abort, found_ack, core_hash, core_done,
    input  cfg_ready, busy, found_valid, found_nonce, found_hash,
    input  exhausted, timeout_err, nonce_cur, core_rst_n, core_start, core_block
  );

  // Sequencer side.
  modport slave (
    input  cfg_valid, cfg_prefix, cfg_target, cfg_nonce_start, cfg_nonce_end,
    input  abort, found_ack, core_hash, core_done,
    output cfg_ready, busy, found_valid, found_nonce, found_hash,
    output exhausted, timeout_err, nonce_cur, core_rst_n, core_start, core_block
  );

endinterface

// File: rtl/mining_sequencer_target_cmp.sv
// Converts the core digest to its little-endian integer form and tests it against the target.
module target_cmp
  import mining_pkg::*;
(
  input  logic [HASH_W-1:0] hash,
  input  logic [HASH_W-1:0] target,
  output logic [HASH_W-1:0] le_c,
  output logic              hit_c
);

  // Byte reversal and unsigned compare, purely combinational.
  always_comb begin
    le_c  = bswap256(hash);
    hit_c = (le_c <= target);
  end

endmodule

// File: rtl/mining_sequencer.sv
// Nonce-sweep controller: resets/starts the core per nonce and checks each digest against the target.
module mining_sequencer
  import mining_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 512,
  parameter bit          STOP_ON_FIRST  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  mining_sequencer_if.slave  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  cfg_t                cfg_q, cfg_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                found_valid_q, found_valid_d;
  logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
  logic [HASH_W-1:0]   found_hash_q, found_hash_d;
  logic                exhausted_q, exhausted_d;
  logic                timeout_q, timeout_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                busy_q, busy_d;
  logic                core_rst_n_q, core_rst_n_d;
  logic                core_start_q, core_start_d;
  logic [BLOCK_W-1:0]  core_block_q, core_block_d;
  logic                abort_go;
  logic [HASH_W-1:0]   le_c;
  logic                hit_c;

  target_cmp u_cmp (
    .hash   (bus.core_hash),
    .target (cfg_q.target),
    .le_c   (le_c),
    .hit_c  (hit_c)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cfg_q         <= '0;
      nonce_q       <= '0;
      tmo_q         <= '0;
      found_valid_q <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      exhausted_q   <= 1'b0;
      timeout_q     <= 1'b0;
      cfg_ready_q   <= 1'b1;
      busy_q        <= 1'b0;
      core_rst_n_q  <= 1'b0;
      core_start_q  <= 1'b0;
      core_block_q  <= '0;
    end else begin
      state_q       <= state_d;
      cfg_q         <= cfg_d;
      nonce_q       <= nonce_d;
      tmo_q         <= tmo_d;
      found_valid_q <= found_valid_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      exhausted_q   <= exhausted_d;
      timeout_q     <= timeout_d;
      cfg_ready_q   <= cfg_ready_d;
      busy_q        <= busy_d;
      core_rst_n_q  <= core_rst_n_d;
      core_start_q  <= core_start_d;
      core_block_q  <= core_block_d;
    end
  end

  // Next-state and next-output logic; abort wins over normal progress except in IDLE/HOLD/DONE.
  always_comb begin
    state_d       = state_q;
    cfg_d         = cfg_q;
    nonce_d       = nonce_q;
    tmo_d         = tmo_q;
    found_valid_d = found_valid_q;
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    exhausted_d   = exhausted_q;
    timeout_d     = timeout_q;
    abort_go      = 1'b0;

    if (bus.abort && (state_q == ST_CRST || state_q == ST_CSTART ||
                      state_q == ST_WAIT || state_q == ST_CHECK)) begin
      abort_go = 1'b1;
      state_d  = ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.cfg_valid && cfg_ready_q) begin
            cfg_d.prefix    = bus.cfg_prefix;
            cfg_d.target    = bus.cfg_target;
            cfg_d.nonce_end = bus.cfg_nonce_end;
            nonce_d         = bus.cfg_nonce_start;
            exhausted_d     = 1'b0;
            timeout_d       = 1'b0;
            found_nonce_d   = '0;
            found_hash_d    = '0;
            state_d         = ST_CRST;
          end
        end
        ST_CRST: state_d = ST_CSTART;
        ST_CSTART: begin
          // Counter tracks cycles elapsed since core_start rose.
          tmo_d   = TMO_W'(1);
          state_d = ST_WAIT;
        end
        ST_WAIT: begin
          if (bus.core_done) begin
            state_d = ST_CHECK;
          end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
        ST_CHECK: begin
          if (hit_c) begin
            found_valid_d = 1'b1;
            found_nonce_d = nonce_q;
            found_hash_d  = le_c;
            state_d       = ST_HOLD;
          end else if (nonce_q == cfg_q.nonce_end) begin
            exhausted_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            nonce_d = nonce_q + NONCE_W'(1);
            state_d = ST_CRST;
          end
        end
        ST_HOLD: begin
          if (bus.found_ack) begin
            found_valid_d = 1'b0;
            if (STOP_ON_FIRST) begin
              state_d = ST_DONE;
            end else if (nonce_q == cfg_q.nonce_end) begin
              exhausted_d = 1'b1;
              state_d     = ST_DONE;
            end else begin
              nonce_d = nonce_q + NONCE_W'(1);
              state_d = ST_CRST;
            end
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end

    cfg_ready_d  = (state_d == ST_IDLE);
    busy_d       = (state_d != ST_IDLE);
    core_start_d = (state_d == ST_CSTART);
    core_rst_n_d = !(state_d == ST_IDLE || state_d == ST_CRST || abort_go);
    core_block_d = {cfg_d.prefix, bswap32(nonce_d)};
  end

  assign bus.cfg_ready   = cfg_ready_q;
  assign bus.busy        = busy_q;
  assign bus.found_valid = found_valid_q;
  assign bus.found_nonce = found_nonce_q;
  assign bus.found_hash  = found_hash_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.timeout_err = timeout_q;
  assign bus.nonce_cur   = nonce_q;
  assign bus.core_rst_n  = core_rst_n_q;
  assign bus.core_start  = core_start_q;
  assign bus.core_block  = core_block_q;

endmodule
